// File: rtl/audio_i2s_tx.sv
// ---------------------------------------------------------------------------
// audio_i2s_tx
//
// Purpose:
//   Final stage of the voice datapath. Takes the 32-bit signed TONE mix,
//   scales it by an arithmetic right shift (GAIN) and turns it into a 16-bit
//   mono sample. It then serialises that sample as a standard I2S stream
//   (the same word on left and right) for the codec DAC. BCLK and LRCLK are
//   derived from CLK.
//
//   Once per frame a new sample is requested from the synth controller.
//   The incoming sample is held in a pending buffer and moved into the frame
//   buffer at the next frame start, so a key sweep can complete anywhere
//   inside the frame.
//
// Parameters:
//   BCLK_HALF   CLK cycles per BCLK half-period (>= 2). A frame lasts
//               64 BCLK periods, which is 128*BCLK_HALF CLK cycles.
//
// Ports:
//   CLK          system clock
//   RESET        synchronous, active-high reset
//   TONE[31:0]   signed mixed sample, captured when TONE_VALID = 1
//   TONE_VALID   one-cycle pulse marking the end of a key sweep
//   GAIN[3:0]    arithmetic right-shift amount applied to TONE
//   MUTE         forces the frame sample to 0 at frame start
//   SAMPLE_REQ   one-cycle pulse at frame start (controller starts a sweep)
//   UNDERRUN     one-cycle pulse when a frame starts with nothing pending
//   AUD_BCLK     I2S bit clock
//   AUD_DACLRCK  I2S word select, 0 = left, 1 = right
//   AUD_DACDAT   I2S serial data, MSB first
//
// Build option:
//   TONE_SAT_EN  when defined, the scaled sample saturates to the range
//                [-32768, 32767]. When undefined, the low 16 bits are kept
//                (wrapping truncation).
// ---------------------------------------------------------------------------
module audio_i2s_tx #(
    parameter int BCLK_HALF = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] TONE,
    input  logic        TONE_VALID,
    input  logic [3:0]  GAIN,
    input  logic        MUTE,
    output logic        SAMPLE_REQ,
    output logic        UNDERRUN,
    output logic        AUD_BCLK,
    output logic        AUD_DACLRCK,
    output logic        AUD_DACDAT
);

    localparam int               DIV_W    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

    typedef enum logic {
        ST_FIRST,
        ST_RUN
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       bit_cnt;
    logic [15:0]      frame_smp;
    logic [15:0]      pend_smp;
    logic             pend_vld;

    logic             div_wrap;
    logic             fall;
    logic             frame_start;
    logic [5:0]       bit_nxt;
    logic [4:0]       slot;
    logic [3:0]       bit_idx;
    logic             ser_bit;
    logic [15:0]      load_smp;
    logic [15:0]      conv_smp;

    // Bit-clock edge detection. A fall is the divider wrap while BCLK is
    // high, and every serial output is updated on a fall.
    always_comb begin
        div_wrap    = (div_cnt == DIV_LAST);
        fall        = div_wrap && AUD_BCLK;
        bit_nxt     = bit_cnt + 6'd1;
        frame_start = fall && (bit_cnt == 6'd63);
        slot        = bit_nxt[4:0];
    end

    // Data bit for the slot being entered. Slot 0 of each channel is the
    // one-BCLK I2S delay after the LRCLK edge. Slots 1..16 carry the sample
    // MSB first, and the remaining slots are zero padding.
    always_comb begin
        bit_idx = 4'(5'd16 - slot);
        ser_bit = 1'b0;
        if (slot >= 5'd1 && slot <= 5'd16) begin
            ser_bit = frame_smp[bit_idx];
        end
    end

    // Sample that the frame buffer takes at frame start. Mute overrides
    // everything. Otherwise a pending sample is used, and if there is none
    // the previous frame's sample is repeated.
    always_comb begin
        load_smp = frame_smp;
        if (MUTE) begin
            load_smp = 16'h0000;
        end else if (pend_vld) begin
            load_smp = pend_smp;
        end
    end

`ifdef TONE_SAT_EN
    logic signed [31:0] shifted;

    // Scale by the gain and clamp to the 16-bit signed range.
    always_comb begin
        shifted = $signed(TONE) >>> GAIN;
        if (shifted > 32'sd32767) begin
            conv_smp = 16'h7FFF;
        end else if (shifted < -32'sd32768) begin
            conv_smp = 16'h8000;
        end else begin
            conv_smp = shifted[15:0];
        end
    end
`else
    // Scale by the gain and keep the low 16 bits (wrapping truncation).
    always_comb begin
        conv_smp = 16'($signed(TONE) >>> GAIN);
    end
`endif

    // Main sequencer: divider, bit counter, serial outputs, sample buffers
    // and the FIRST/RUN state. The TONE_VALID update comes after the
    // frame-start block on purpose. When both happen in the same cycle, the
    // frame takes the old pending sample and the new sample stays pending.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_FIRST;
            div_cnt     <= '0;
            bit_cnt     <= 6'd63;
            frame_smp   <= 16'h0000;
            pend_smp    <= 16'h0000;
            pend_vld    <= 1'b0;
            SAMPLE_REQ  <= 1'b0;
            UNDERRUN    <= 1'b0;
            AUD_BCLK    <= 1'b0;
            AUD_DACLRCK <= 1'b0;
            AUD_DACDAT  <= 1'b0;
        end else begin
            SAMPLE_REQ <= 1'b0;
            UNDERRUN   <= 1'b0;

            if (div_wrap) begin
                div_cnt  <= '0;
                AUD_BCLK <= ~AUD_BCLK;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (fall) begin
                bit_cnt     <= bit_nxt;
                AUD_DACLRCK <= bit_nxt[5];
                AUD_DACDAT  <= ser_bit;
            end

            if (frame_start) begin
                SAMPLE_REQ <= 1'b1;
                frame_smp  <= load_smp;
                pend_vld   <= 1'b0;
                if (!pend_vld && state == ST_RUN) begin
                    UNDERRUN <= 1'b1;
                end
                state <= ST_RUN;
            end

            if (TONE_VALID) begin
                pend_smp <= conv_smp;
                pend_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// ---------------------------------------------------------------------------
// tb_audio_i2s_tx
//
// Self-checking bench for audio_i2s_tx (BCLK_HALF = 8).
//
// Every output is compared on every clock against a reference model. The
// model tracks time since reset release (frame starts occur every
// 128*BCLK_HALF cycles, and bit slots every 2*BCLK_HALF cycles) and keeps a
// per-frame table of the words that should be sent.
//
// The run has two parts:
//   - Directed frames: serial format, gain, underrun/repeat, overwrite,
//     collision on the frame-start cycle, mute.
//   - Random frames, followed by a reset in the middle of a left slot and a
//     short rerun of the timing.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_audio_i2s_tx;

    localparam int BH         = 8;
    localparam int FRAME      = 128 * BH;
    localparam int SLOT       = 2 * BH;
    localparam int FIRST_FALL = 2 * BH;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] TONE;
    logic        TONE_VALID;
    logic [3:0]  GAIN;
    logic        MUTE;
    logic        SAMPLE_REQ;
    logic        UNDERRUN;
    logic        AUD_BCLK;
    logic        AUD_DACLRCK;
    logic        AUD_DACDAT;

    audio_i2s_tx #(.BCLK_HALF(BH)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .TONE        (TONE),
        .TONE_VALID  (TONE_VALID),
        .GAIN        (GAIN),
        .MUTE        (MUTE),
        .SAMPLE_REQ  (SAMPLE_REQ),
        .UNDERRUN    (UNDERRUN),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_DACLRCK (AUD_DACLRCK),
        .AUD_DACDAT  (AUD_DACDAT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          fr;
        int          pos;
        logic [31:0] tone;
        logic [3:0]  gain;
    } pulse_t;

    pulse_t      plan[$];
    bit          mute_plan[0:63];

    int          checks   = 0;
    int          failures = 0;
    int          t        = 0;

    logic [15:0] exp_frame[0:63];
    logic [15:0] m_pend;
    bit          m_pend_v;
    bit          exp_req;
    bit          exp_under;

    // Compare one observed value with its expected value and report a
    // difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s t=%0d observed=%0h expected=%0h", tag, t, observed, expected);
        end
    endtask

    // Scale by the gain using floor division by 2^gain, then saturate or
    // wrap to 16 bits.
    function automatic logic [15:0] convert(input logic [31:0] tone, input logic [3:0] gain);
        longint s;
        longint d;
        s = longint'($signed(tone));
        d = longint'(1) << gain;
        if (s >= 0) s = s / d;
        else        s = -((-s + d - 1) / d);
`ifdef TONE_SAT_EN
        if (s > 32767)       s = 32767;
        else if (s < -32768) s = -32768;
`endif
        return 16'(s);
    endfunction

    // Drive the inputs for edge number tn after reset release.
    task automatic applyStimulus(input int tn);
        int fr;
        int pos;
        RESET      = 1'b0;
        TONE_VALID = 1'b0;
        TONE       = $urandom;
        GAIN       = 4'($urandom);
        MUTE       = 1'($urandom);
        if (tn >= FIRST_FALL) begin
            fr  = (tn - FIRST_FALL) / FRAME;
            pos = (tn - FIRST_FALL) % FRAME;
            if (pos == 0) MUTE = mute_plan[fr];
            foreach (plan[i]) begin
                if (plan[i].fr == fr && plan[i].pos == pos) begin
                    TONE_VALID = 1'b1;
                    TONE       = plan[i].tone;
                    GAIN       = plan[i].gain;
                end
            end
        end
    endtask

    // Advance the reference model by one clock edge, using the inputs that
    // were present at that edge.
    task automatic modelStep(input int tn);
        int k;
        exp_req   = 1'b0;
        exp_under = 1'b0;
        if (tn >= FIRST_FALL && (tn - FIRST_FALL) % FRAME == 0) begin
            k         = (tn - FIRST_FALL) / FRAME;
            exp_req   = 1'b1;
            exp_under = !m_pend_v && (k > 0);
            if (MUTE)          exp_frame[k] = 16'h0000;
            else if (m_pend_v) exp_frame[k] = m_pend;
            else               exp_frame[k] = (k > 0) ? exp_frame[k-1] : 16'h0000;
            m_pend_v = 1'b0;
        end
        if (TONE_VALID) begin
            m_pend   = convert(TONE, GAIN);
            m_pend_v = 1'b1;
        end
    endtask

    // Compare all outputs with the values expected after edge tn.
    task automatic compareAll(input int tn);
        int          j;
        int          sl;
        int          c;
        int          k;
        logic [15:0] smp;
        bit          e_bclk;
        bit          e_lr;
        bit          e_dat;
        e_bclk = ((tn / BH) % 2) == 1;
        e_lr   = 1'b0;
        e_dat  = 1'b0;
        if (tn >= FIRST_FALL) begin
            j    = (tn - FIRST_FALL) / SLOT;
            sl   = j % 64;
            c    = sl % 32;
            k    = j / 64;
            e_lr = (sl >= 32);
            smp  = exp_frame[k];
            if (c >= 1 && c <= 16) e_dat = smp[16 - c];
        end
        checkOutput("bclk",       AUD_BCLK,    e_bclk);
        checkOutput("lrck",       AUD_DACLRCK, e_lr);
        checkOutput("dacdat",     AUD_DACDAT,  e_dat);
        checkOutput("sample_req", SAMPLE_REQ,  exp_req);
        checkOutput("underrun",   UNDERRUN,    exp_under);
    endtask

    // Run nEdges clocks after reset release, starting from a freshly reset
    // model.
    task automatic runPhase(input int nEdges);
        m_pend_v = 1'b0;
        m_pend   = 16'h0000;
        foreach (exp_frame[i]) exp_frame[i] = 16'h0000;
        for (int tn = 1; tn <= nEdges; tn++) begin
            @(negedge CLK);
            applyStimulus(tn);
            @(posedge CLK);
            t = tn;
            modelStep(tn);
            #1;
            compareAll(tn);
        end
    endtask

    // Check that every output is at its reset value.
    task automatic checkResetOutputs();
        checkOutput("rst_bclk",       AUD_BCLK,    0);
        checkOutput("rst_lrck",       AUD_DACLRCK, 0);
        checkOutput("rst_dacdat",     AUD_DACDAT,  0);
        checkOutput("rst_sample_req", SAMPLE_REQ,  0);
        checkOutput("rst_underrun",   UNDERRUN,    0);
    endtask

    initial begin
        logic [31:0] tmp;
        pulse_t      p;

        RESET      = 1'b1;
        TONE       = 32'h0;
        TONE_VALID = 1'b0;
        GAIN       = 4'h0;
        MUTE       = 1'b0;

        foreach (mute_plan[i]) mute_plan[i] = 1'b0;

        // Directed frames (fr = frame window, pos = cycle offset from that
        // window's frame start).
        plan.push_back('{0, 100, 32'h0000A5C3, 4'd0});
        plan.push_back('{1, 200, 32'h00123456, 4'd4});
        plan.push_back('{3,  50, 32'h00001111, 4'd0});
        plan.push_back('{3, 300, 32'h00002222, 4'd0});
        plan.push_back('{4, 500, 32'h00004444, 4'd0});
        plan.push_back('{5,   0, 32'h00003333, 4'd0});
        plan.push_back('{6,  10, 32'h00007FFF, 4'd0});
        plan.push_back('{8, 700, 32'hFFF00000, 4'd4});
        mute_plan[7] = 1'b1;

        // Random frames.
        for (int fr = 9; fr <= 20; fr++) begin
            int n;
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
                tmp = $urandom;
                if ($urandom_range(0, 1) == 1) tmp = {{16{tmp[15]}}, tmp[15:0]};
                p.fr   = fr;
                p.pos  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, FRAME - 1);
                p.tone = tmp;
                p.gain = 4'($urandom);
                plan.push_back(p);
            end
            mute_plan[fr] = ($urandom_range(0, 4) == 0);
        end

        repeat (3) begin
            @(posedge CLK);
            #1;
            checkResetOutputs();
        end

        // Run to slot 10 of the left channel in frame 21, then reset.
        runPhase(FIRST_FALL + 21 * FRAME + 10 * SLOT + 5);

        @(negedge CLK);
        RESET      = 1'b1;
        TONE_VALID = 1'b1;
        TONE       = 32'h00005555;
        MUTE       = 1'b0;
        @(posedge CLK);
        #1;
        checkResetOutputs();

        // Timing must restart exactly as after the first reset.
        runPhase(FIRST_FALL + 3 * FRAME + 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
